// File: rtl/cpu_pkg.sv
// Shared core types: decoded control bundle, ALU opcodes and datapath widths.
package cpu_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_unit.sv
// Load-use detection: a load in EX feeding either ID source forces one bubble.
module hazard_unit #(
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  flush,
    output logic                  hazard,
    output logic                  stall
);

    logic rd_nz;
    logic rd_hit;

    assign rd_nz  = (ex_rd != '0);
    assign rd_hit = (ex_rd == id_rs1) || (ex_rd == id_rs2);
    assign hazard = id_valid && ex_valid && ex_mem_read && rd_nz && rd_hit;
    // A redirect discards the ID instruction, so holding IF/ID is pointless.
    assign stall  = hazard && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB same-cycle bypass and load-use bubble.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     read_data_1,
    input  logic [DATA_W-1:0]     read_data_2,
    input  logic [DATA_W-1:0]     id_imm,
    input  ctrl_t                 id_ctrl,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    output logic                  stall_if_id,
    output logic                  ex_valid,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]     ex_op1,
    output logic [DATA_W-1:0]     ex_op2,
    output logic [DATA_W-1:0]     ex_imm,
    output ctrl_t                 ex_ctrl
);

    logic              hazard;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              byp1;
    logic              byp2;

    hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (ex_valid),
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_rd       (ex_rd),
        .flush       (flush),
        .hazard      (hazard),
        .stall       (stall_if_id)
    );

    // Register file lacks write-through, so WB data is forwarded here.
    assign byp1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
    assign byp2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

    always_comb begin
        op1 = read_data_1;
        op2 = read_data_2;
        if (byp1) op1 = wb_data;
        if (byp2) op2 = wb_data;
        if (id_rs1 == '0) op1 = '0;
        if (id_rs2 == '0) op2 = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= CTRL_NOP;
        end else if (flush || hazard) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_op1   <= '0;
            ex_op2   <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= CTRL_NOP;
        end else begin
            ex_valid <= id_valid;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_op1   <= op1;
            ex_op2   <= op2;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, bypass, load-use, flush, reset.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] read_data_1, read_data_2, id_imm;
    ctrl_t       id_ctrl;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        flush;
    logic        stall_if_id;
    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [63:0] ex_op1, ex_op2, ex_imm;
    ctrl_t       ex_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .read_data_1  (read_data_1),
        .read_data_2  (read_data_2),
        .id_imm       (id_imm),
        .id_ctrl      (id_ctrl),
        .wb_reg_write (wb_reg_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .stall_if_id  (stall_if_id),
        .ex_valid     (ex_valid),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_op1       (ex_op1),
        .ex_op2       (ex_op2),
        .ex_imm       (ex_imm),
        .ex_ctrl      (ex_ctrl)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctrl_t mk(input logic rw, input logic mr,
                                 input logic mw, input logic mtr,
                                 input logic as, input alu_op_e op);
        ctrl_t c;
        c.reg_write  = rw;
        c.mem_read   = mr;
        c.mem_write  = mw;
        c.mem_to_reg = mtr;
        c.alu_src    = as;
        c.alu_op     = op;
        return c;
    endfunction

    task automatic present(input logic v, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [4:0] d,
                           input logic [63:0] r1, input logic [63:0] r2,
                           input logic [63:0] im, input ctrl_t c);
        id_valid    = v;
        id_rs1      = s1;
        id_rs2      = s2;
        id_rd       = d;
        read_data_1 = r1;
        read_data_2 = r2;
        id_imm      = im;
        id_ctrl     = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    ctrl_t c_add, c_ld;

    initial begin
        c_add = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
        c_ld  = mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
        rst = 1'b1;
        flush = 1'b0;
        wb_reg_write = 1'b0;
        wb_rd = '0;
        wb_data = '0;
        present(1'b1, 5'd7, 5'd7, 5'd7, 64'h1, 64'h2, 64'h3, c_ld);
        tick();
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_ctrl", {55'd0, ex_ctrl}, 64'd0);
        chk("rst_stall", {63'd0, stall_if_id}, 64'd0);
        rst = 1'b0;

        // plain capture
        present(1'b1, 5'd3, 5'd4, 5'd5, 64'h11, 64'h22, -64'sd8, c_add);
        tick();
        chk("cap_op1", ex_op1, 64'h11);
        chk("cap_op2", ex_op2, 64'h22);
        chk("cap_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("cap_valid", {63'd0, ex_valid}, 64'd1);
        chk("cap_rd", {59'd0, ex_rd}, 64'd5);
        chk("cap_ctrl", {55'd0, ex_ctrl}, {55'd0, c_add});

        // WB bypass
        wb_reg_write = 1'b1;
        wb_rd = 5'd3;
        wb_data = 64'hDEAD;
        present(1'b1, 5'd3, 5'd4, 5'd5, 64'h5, 64'h22, 64'h0, c_add);
        tick();
        chk("byp_op1", ex_op1, 64'hDEAD);
        chk("byp_op2", ex_op2, 64'h22);
        wb_rd = 5'd0;
        present(1'b1, 5'd0, 5'd4, 5'd5, 64'h5, 64'h22, 64'h0, c_add);
        tick();
        chk("byp_r0", ex_op1, 64'h0);
        wb_rd = 5'd4;
        present(1'b1, 5'd6, 5'd4, 5'd5, 64'h66, 64'h22, 64'h0, c_add);
        tick();
        chk("nobyp_op1", ex_op1, 64'h66);
        chk("byp_op2b", ex_op2, 64'hDEAD);
        wb_reg_write = 1'b0;

        // invalid ID: ctrl forced to zero
        present(1'b0, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0, c_add);
        tick();
        chk("inv_valid", {63'd0, ex_valid}, 64'd0);
        chk("inv_ctrl", {55'd0, ex_ctrl}, 64'd0);

        // load-use on rs2
        present(1'b1, 5'd1, 5'd2, 5'd7, 64'h1, 64'h2, 64'h10, c_ld);
        tick();
        chk("lu_ld_in_ex", {63'd0, ex_ctrl.mem_read}, 64'd1);
        present(1'b1, 5'd9, 5'd7, 5'd8, 64'h9, 64'h77, 64'h0, c_add);
        #1;
        chk("lu_stall", {63'd0, stall_if_id}, 64'd1);
        tick();
        chk("lu_bub_valid", {63'd0, ex_valid}, 64'd0);
        chk("lu_bub_ctrl", {55'd0, ex_ctrl}, 64'd0);
        chk("lu_stall_clr", {63'd0, stall_if_id}, 64'd0);
        tick();
        chk("lu_cap_valid", {63'd0, ex_valid}, 64'd1);
        chk("lu_cap_rs2", {59'd0, ex_rs2}, 64'd7);
        chk("lu_cap_op2", ex_op2, 64'h77);

        // load to r0 never stalls
        present(1'b1, 5'd0, 5'd1, 5'd0, 64'h0, 64'h1, 64'h0, c_ld);
        tick();
        present(1'b1, 5'd0, 5'd0, 5'd2, 64'h5, 64'h5, 64'h0, c_add);
        #1;
        chk("r0_nostall", {63'd0, stall_if_id}, 64'd0);
        tick();
        chk("r0_valid", {63'd0, ex_valid}, 64'd1);

        // flush beats hazard
        present(1'b1, 5'd1, 5'd2, 5'd7, 64'h1, 64'h2, 64'h0, c_ld);
        tick();
        present(1'b1, 5'd7, 5'd3, 5'd8, 64'h1, 64'h2, 64'h0, c_add);
        flush = 1'b1;
        #1;
        chk("fl_hz_stall", {63'd0, stall_if_id}, 64'd0);
        tick();
        chk("fl_hz_valid", {63'd0, ex_valid}, 64'd0);
        chk("fl_hz_ctrl", {55'd0, ex_ctrl}, 64'd0);
        present(1'b1, 5'd1, 5'd2, 5'd3, 64'h1, 64'h2, 64'h0, c_add);
        tick();
        chk("fl_valid", {63'd0, ex_valid}, 64'd0);
        chk("fl_rw", {63'd0, ex_ctrl.reg_write}, 64'd0);
        flush = 1'b0;

        // back-to-back loads: lw r1; lw r2,(r1); add r4,r2,r3
        stalls = 0;
        present(1'b1, 5'd0, 5'd0, 5'd1, 64'h0, 64'h0, 64'h0, c_ld);
        #1;
        if (stall_if_id) stalls++;
        tick();
        chk("bb_s0_ld", {62'd0, ex_ctrl.mem_read, ex_valid}, 64'd3);
        chk("bb_s0_rd", {59'd0, ex_rd}, 64'd1);
        present(1'b1, 5'd1, 5'd0, 5'd2, 64'h0, 64'h0, 64'h0, c_ld);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (stall_if_id) stalls++;
            tick();
            case (i)
                0: chk("bb_s1_bub", {63'd0, ex_valid}, 64'd0);
                1: begin
                    chk("bb_s2_ld", {62'd0, ex_ctrl.mem_read, ex_valid}, 64'd3);
                    chk("bb_s2_rd", {59'd0, ex_rd}, 64'd2);
                    present(1'b1, 5'd2, 5'd3, 5'd4, 64'h0, 64'h0, 64'h0, c_add);
                end
                2: chk("bb_s3_bub", {63'd0, ex_valid}, 64'd0);
                default: begin
                    chk("bb_s4_add", {62'd0, ex_ctrl.mem_read, ex_valid}, 64'd1);
                    chk("bb_s4_rd", {59'd0, ex_rd}, 64'd4);
                end
            endcase
        end
        chk("bb_stalls", 64'(stalls), 64'd2);

        // async reset mid-stream
        present(1'b1, 5'd3, 5'd4, 5'd5, 64'h11, 64'h22, 64'h33, c_add);
        tick();
        chk("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, ex_valid}, 64'd0);
        chk("arst_ctrl", {55'd0, ex_ctrl}, 64'd0);
        chk("arst_op1", ex_op1, 64'd0);
        chk("arst_imm", ex_imm, 64'd0);
        chk("arst_rd", {49'd0, ex_rs1, ex_rs2, ex_rd}, 64'd0);
        chk("arst_stall", {63'd0, stall_if_id}, 64'd0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage, directly downstream of the 32x64 register file read ports.
- Captures the register-file operands, immediate and decoded control each cycle, and presents them registered to the EX stage.
- Adds WB-to-ID same-cycle bypass, because the register file has no internal write-through.
- Detects load-use hazards: stalls IF/ID and inserts a single bubble into EX.

Parameters:
DATA_W, 64, operand/immediate width
REG_ADDR_W, 5, register index width (32 registers, r0 hard zero)
ALU_OP_W, 4, ALU operation code width

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_ADDR_W  source 1 index (also drives read_register_1)
id_rs2  in  REG_ADDR_W  source 2 index (also drives read_register_2)
id_rd  in  REG_ADDR_W  destination index
read_data_1  in  DATA_W  register file operand 1
read_data_2  in  DATA_W  register file operand 2
id_imm  in  DATA_W  sign-extended immediate
id_ctrl  in  ctrl_t  {reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op}
wb_reg_write  in  1  WB writes the register file this cycle
wb_rd  in  REG_ADDR_W  WB destination index
wb_data  in  DATA_W  WB write data
flush  in  1  branch/jump redirect; squash ID instruction
stall_if_id  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a valid instruction
ex_rs1, ex_rs2, ex_rd  out  REG_ADDR_W  registered indices for EX forwarding
ex_op1, ex_op2  out  DATA_W  registered operands
ex_imm  out  DATA_W  registered immediate
ex_ctrl  out  ctrl_t  registered control

Behaviour:
- Reset (async, any time, including mid-stall): all ex_* outputs are 0, ex_ctrl is all-zero, ex_valid is 0. stall_if_id is 0 while rst is high. The first capture occurs on the first posedge after rst deasserts.
- Bypass, combinational: op1 = (wb_reg_write && wb_rd!=0 && wb_rd==id_rs1) ? wb_data : read_data_1; op2 is identical using id_rs2/read_data_2. Any source equal to 0 yields 0 regardless of inputs.
- Hazard, combinational: hazard = id_valid && ex_valid && ex_ctrl.mem_read && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
- stall_if_id = hazard && !flush.
- Per posedge, priority order:
  1. flush: load a bubble (ex_valid=0, ex_ctrl=0). Data fields are don't-care but held at 0.
  2. hazard: load a bubble. IF/ID holds via stall_if_id, so the same instruction is re-presented next cycle.
  3. else: capture id_valid, indices, op1, op2, id_imm and id_ctrl. If id_valid=0, ex_ctrl is forced to 0.
- Latency: 1 cycle from ID presentation to ex_* outputs.
- A load-use stall lasts exactly 1 cycle: the bubble clears the hazard on the next cycle, and that load is then in MEM and covered by EX forwarding.
- Back-to-back loads with consecutive dependencies each stall exactly 1 cycle.
- A bubble never has reg_write or mem_write asserted.
- Simultaneous flush and hazard: flush wins and stall_if_id=0.
- The WB bypass and a hazard may coincide: the stall takes effect and the bypass is re-evaluated on the replay.
- No clock enable: the stage captures every cycle unless rules 1 or 2 apply.

Decomposition:
- Shared package cpu_pkg:
  - ctrl_t packed struct
  - alu_op enum
  - REG_ADDR_W and DATA_W constants
  - CTRL_NOP = '0
- One natural sub-module: hazard_unit (combinational load-use detect plus stall), reused later by the EX forwarding unit.
- Bypass muxes stay inline.

Test Plan:
- Reset: assert rst mid-stream while ex_valid=1 -> ex_valid=0, ex_ctrl=0 and all ex_* fields 0 immediately (async), before any clk edge.
- Plain capture: id_valid=1, rs1=3, rs2=4, read_data_1=0x11, read_data_2=0x22, imm=-8, alu_op=ADD -> next cycle ex_op1=0x11, ex_op2=0x22, ex_imm=0xFFFF_FFFF_FFFF_FFF8, ex_valid=1.
- WB bypass: wb_reg_write=1, wb_rd=3, wb_data=0xDEAD, id_rs1=3, read_data_1=0x5 -> ex_op1=0xDEAD. Repeat with wb_rd=0 and id_rs1=0 -> ex_op1=0.
- Load-use: EX holds a load with rd=7; ID presents rs2=7 -> stall_if_id=1 for exactly 1 cycle, ex_valid=0 and ex_ctrl=0 for 1 cycle, then the instruction is captured with ex_valid=1. Load rd=0 with rs1=0 -> no stall.
- Flush priority: hazard condition present and flush=1 on the same cycle -> stall_if_id=0 and a bubble in EX. Flush alone with a valid ID -> ex_valid=0 and ex_ctrl.reg_write=0.
- Back-to-back loads: lw r1, lw r2 using r1, add using r2 -> exactly two single-cycle stalls, and the final ex sequence is load, bubble, load, bubble, add.
